// File: rtl/alert_signal_conditioner_if.sv
// Alert conditioner bus: raw asynchronous alert lines in, clean levels and event count out.
interface alert_signal_conditioner_if #(
  parameter int unsigned CNT_W = 8
);
  logic             raw_green;
  logic             raw_yellow;
  logic             raw_red;
  logic             green;
  logic             yellow;
  logic             red;
  logic             level_change;
  logic [CNT_W-1:0] red_events;

  modport master (
    output raw_green, raw_yellow, raw_red,
    input  green, yellow, red, level_change, red_events
  );

  modport slave (
    input  raw_green, raw_yellow, raw_red,
    output green, yellow, red, level_change, red_events
  );
endinterface

// File: rtl/alert_signal_conditioner.sv
// Synchronise -> debounce -> prioritise -> minimum-hold front end for three alert lines.
// Optional STICKY_RED_EN: once RED is entered it is held until reset.
module alert_signal_conditioner #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input logic                        clock,
  input logic                        reset,
  alert_signal_conditioner_if.slave  bus
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    RED    = 2'b11
  } state_e;

  // Channel index: 0 = green, 1 = yellow, 2 = red
  logic [NCH-1:0]    sync1_q, sync1_d;
  logic [NCH-1:0]    sync2_q, sync2_d;
  logic [NCH-1:0]    clean_q, clean_d;
  logic [DB_W-1:0]   db_cnt_q [NCH];
  logic [DB_W-1:0]   db_cnt_d [NCH];
  state_e            state_q, state_d;
  state_e            request;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              green_q, green_d;
  logic              yellow_q, yellow_d;
  logic              red_q, red_d;
  logic              level_change_q, level_change_d;
  logic [CNT_W-1:0]  red_events_q, red_events_d;
  logic              entered;

  always_comb begin
    sync1_d        = {bus.raw_red, bus.raw_yellow, bus.raw_green};
    sync2_d        = sync1_q;
    clean_d        = clean_q;
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    red_events_d   = red_events_q;
    request        = IDLE;
    entered        = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      db_cnt_d[i] = '0;
    end

    // Accept a change only after DEBOUNCE consecutive differing cycles
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] != clean_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
          clean_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end

    if (clean_q[2]) begin
      request = RED;
    end else if (clean_q[1]) begin
      request = YELLOW;
    end else if (clean_q[0]) begin
      request = GREEN;
    end

    // Escalation to RED and leaving IDLE bypass the minimum hold
    if (request != state_q) begin
      if (request == RED || state_q == IDLE || hold_cnt_q == HOLD_W'(MIN_HOLD)) begin
        state_d = request;
      end
    end
`ifdef STICKY_RED_EN
    if (state_q == RED) begin
      state_d = RED;
    end
`else
`endif

    entered = (state_d != state_q);
    if (entered) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_W'(MIN_HOLD)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end

    if (entered && state_d == RED && red_events_q != {CNT_W{1'b1}}) begin
      red_events_d = red_events_q + CNT_W'(1);
    end

    level_change_d = entered;
    green_d        = (state_d == GREEN);
    yellow_d       = (state_d == YELLOW);
    red_d          = (state_d == RED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      clean_q        <= '0;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      green_q        <= 1'b0;
      yellow_q       <= 1'b0;
      red_q          <= 1'b0;
      level_change_q <= 1'b0;
      red_events_q   <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      clean_q        <= clean_d;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      green_q        <= green_d;
      yellow_q       <= yellow_d;
      red_q          <= red_d;
      level_change_q <= level_change_d;
      red_events_q   <= red_events_d;
    end
  end

  assign bus.green        = green_q;
  assign bus.yellow       = yellow_q;
  assign bus.red          = red_q;
  assign bus.level_change = level_change_q;
  assign bus.red_events   = red_events_q;

  // Mutually exclusive output levels
  a_onehot0 : assert property (@(posedge clock) disable iff (reset)
                               $onehot0({green_q, yellow_q, red_q}));

endmodule

// File: tb/tb_alert_signal_conditioner.sv
// Scoreboard bench: stimulus queues expected level events and snapshots; a monitor checks them.
module tb_alert_signal_conditioner;

  localparam int unsigned CNT_W = 2;

  typedef struct {
    string name;
    logic  g;
    logic  y;
    logic  r;
    logic  lc;
    int    ev;
    int    at;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;
  bit   done   = 1'b0;
  int   n;
  exp_t evq[$];
  exp_t snapq[$];

  alert_signal_conditioner_if #(.CNT_W(CNT_W)) bus ();

  alert_signal_conditioner #(
    .DEBOUNCE (3),
    .MIN_HOLD (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic set_raw(input logic g, input logic y, input logic r);
    bus.raw_green  = g;
    bus.raw_yellow = y;
    bus.raw_red    = r;
  endtask

  task automatic push_ev(input string name, input logic g, input logic y, input logic r,
                         input int ev, input int at);
    exp_t e;
    e.name = name; e.g = g; e.y = y; e.r = r; e.lc = 1'b1; e.ev = ev; e.at = at;
    evq.push_back(e);
  endtask

  task automatic push_snap(input string name, input logic g, input logic y, input logic r,
                           input int ev, input int at);
    exp_t e;
    e.name = name; e.g = g; e.y = y; e.r = r; e.lc = 1'b0; e.ev = ev; e.at = at;
    snapq.push_back(e);
  endtask

  // Monitor: compares on every level_change pulse and at each scheduled snapshot edge
  always @(negedge clock) begin
    exp_t e;
    if (bus.level_change === 1'b1) begin
      total++;
      if (evq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got g%0b y%0b r%0b ev%0d @%0d, wanted no level change",
                 bus.green, bus.yellow, bus.red, bus.red_events, edge_n);
      end else begin
        e = evq.pop_front();
        if (bus.green !== e.g || bus.yellow !== e.y || bus.red !== e.r ||
            int'(bus.red_events) != e.ev || edge_n != e.at) begin
          bad++;
          $display("FAIL %s: got g%0b y%0b r%0b ev%0d @%0d, want g%0b y%0b r%0b ev%0d @%0d",
                   e.name, bus.green, bus.yellow, bus.red, bus.red_events, edge_n,
                   e.g, e.y, e.r, e.ev, e.at);
        end
      end
    end
    if (snapq.size() > 0 && snapq[0].at <= edge_n) begin
      e = snapq.pop_front();
      total++;
      if (bus.green !== e.g || bus.yellow !== e.y || bus.red !== e.r ||
          bus.level_change !== e.lc || int'(bus.red_events) != e.ev || edge_n != e.at) begin
        bad++;
        $display("FAIL %s: got g%0b y%0b r%0b lc%0b ev%0d @%0d, want g%0b y%0b r%0b lc%0b ev%0d @%0d",
                 e.name, bus.green, bus.yellow, bus.red, bus.level_change, bus.red_events, edge_n,
                 e.g, e.y, e.r, e.lc, e.ev, e.at);
      end
    end
    if (!reset && (int'(bus.green) + int'(bus.yellow) + int'(bus.red)) > 1) begin
      total++;
      bad++;
      $display("FAIL exclusive_levels: got g%0b y%0b r%0b @%0d, want at most one high",
               bus.green, bus.yellow, bus.red, edge_n);
    end
    if (done) begin
      total++;
      if (evq.size() != 0 || snapq.size() != 0) begin
        bad++;
        $display("FAIL pending_expectations: got %0d events and %0d snapshots left, want 0 and 0",
                 evq.size(), snapq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_raw(1'b0, 1'b0, 1'b0);
    tick(3);
    push_snap("reset_state", 1'b0, 1'b0, 1'b0, 0, edge_n + 1);
    tick(1);
    reset = 1'b0;

    // T1: green from IDLE, latency 2 + DEBOUNCE after the first sampling edge
    n = edge_n;
    set_raw(1'b1, 1'b0, 1'b0);
    push_ev("t1_green", 1'b1, 1'b0, 1'b0, 0, n + 6);
    tick(12);

    // T2: two-cycle red glitch is filtered
    n = edge_n;
    set_raw(1'b1, 1'b0, 1'b1);
    tick(2);
    set_raw(1'b1, 1'b0, 1'b0);
    push_snap("t2_glitch", 1'b1, 1'b0, 1'b0, 0, n + 12);
    tick(14);

    // T3: short yellow episode; its drop is held back until the minimum hold expires
    n = edge_n;
    set_raw(1'b1, 1'b1, 1'b0);
    tick(3);
    set_raw(1'b1, 1'b0, 1'b0);
    push_ev("t3_yellow", 1'b0, 1'b1, 1'b0, 0, n + 6);
    push_ev("t3_back_green", 1'b1, 1'b0, 1'b0, 0, n + 11);
    tick(14);

    // T4: red arrives one cycle after yellow and bypasses the hold
    n = edge_n;
    set_raw(1'b1, 1'b1, 1'b0);
    tick(1);
    set_raw(1'b1, 1'b1, 1'b1);
    push_ev("t4_yellow", 1'b0, 1'b1, 1'b0, 0, n + 6);
    push_ev("t4_red", 1'b0, 1'b0, 1'b1, 1, n + 7);
    tick(12);

`ifdef STICKY_RED_EN
    // T6: RED stays latched with all raw lines low
    n = edge_n;
    set_raw(1'b0, 1'b0, 1'b0);
    push_snap("t6_sticky", 1'b0, 1'b0, 1'b1, 1, n + 50);
    tick(52);
`else
    n = edge_n;
    set_raw(1'b1, 1'b0, 1'b0);
    push_ev("t4_leave_red", 1'b1, 1'b0, 1'b0, 1, n + 6);
    tick(12);

    // T5: four more red episodes; the 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      n = edge_n;
      set_raw(1'b1, 1'b0, 1'b1);
      push_ev($sformatf("t5_red_%0d", i), 1'b0, 1'b0, 1'b1, (i + 2 > 3) ? 3 : i + 2, n + 6);
      tick(10);
      if (i < 3) begin
        n = edge_n;
        set_raw(1'b1, 1'b0, 1'b0);
        push_ev($sformatf("t5_green_%0d", i), 1'b1, 1'b0, 1'b0, (i + 2 > 3) ? 3 : i + 2, n + 6);
        tick(10);
      end
    end
`endif

    // Reset while RED: everything clears on the next edge
    n = edge_n;
    reset = 1'b1;
    set_raw(1'b0, 1'b0, 1'b0);
    push_snap("reset_mid_red", 1'b0, 1'b0, 1'b0, 0, n + 1);
    tick(1);
    reset = 1'b0;

    // Fresh start after reset: yellow from IDLE
    n = edge_n;
    set_raw(1'b0, 1'b1, 1'b0);
    push_ev("post_reset_yellow", 1'b0, 1'b1, 1'b0, 0, n + 6);
    tick(12);

    done = 1'b1;
    tick(3);
  end

endmodule
